// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: a bitwise logic unit with eight operations on two W-bit
// operands. The result passes through STAGES register stages under a
// valid/ready handshake with a single global stall. Zero and all-ones flags
// travel with the result. A wrapping counter counts completed output beats.
module logic_unit_pipe #(
  parameter int W      = 8,
  parameter int STAGES = 2,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [2:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out,
  output logic          out_zero,
  output logic          out_ones,
  output logic [CW-1:0] txn_count
);

  logic [W-1:0]  func_result;
  logic [W-1:0]  flag_src;
  logic          advance;
  logic [STAGES-1:0] valid_reg;
  logic [W-1:0]  data_reg [STAGES];
  logic          zero_reg;
  logic          ones_reg;
  logic [CW-1:0] txn_count_reg;

  // Any output stall freezes the whole pipe. Empty interior stages are not
  // collapsed, so in_ready depends only on the output side.
  assign advance  = !valid_reg[STAGES-1] || out_ready;
  assign in_ready = advance;

  // Operation select applied at the input, before the first register
  always_comb begin
    func_result = '0;
    case (in_op)
      3'b000:  func_result = in_a & in_b;
      3'b001:  func_result = in_a | in_b;
      3'b010:  func_result = in_a ^ in_b;
      3'b011:  func_result = ~(in_a & in_b);
      3'b100:  func_result = ~(in_a | in_b);
      3'b101:  func_result = ~(in_a ^ in_b);
      3'b110:  func_result = ~in_a;
      default: func_result = in_a;
    endcase
  end

  // First stage captures the input beat (a bubble when in_valid is low)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg[0] <= 1'b0;
      data_reg[0]  <= '0;
    end else if (advance) begin
      valid_reg[0] <= in_valid;
      data_reg[0]  <= func_result;
    end
  end

  // Remaining stages shift from their predecessor together on advance
  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_reg[gi] <= 1'b0;
        data_reg[gi]  <= '0;
      end else if (advance) begin
        valid_reg[gi] <= valid_reg[gi-1];
        data_reg[gi]  <= data_reg[gi-1];
      end
    end
  end

  // The flags are computed from whatever enters the last stage
  if (STAGES == 1) begin : g_flag_direct
    assign flag_src = func_result;
  end else begin : g_flag_staged
    assign flag_src = data_reg[STAGES-2];
  end

  // The flags are registered alongside the last-stage data so they stay aligned
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_reg <= 1'b0;
      ones_reg <= 1'b0;
    end else if (advance) begin
      zero_reg <= (flag_src == '0);
      ones_reg <= (flag_src == '1);
    end
  end

  // Count completed output handshakes, wrapping naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_count_reg <= '0;
    end else if (valid_reg[STAGES-1] && out_ready) begin
      txn_count_reg <= txn_count_reg + CW'(1);
    end
  end

  assign out_valid = valid_reg[STAGES-1];
  assign out       = data_reg[STAGES-1];
  assign out_zero  = zero_reg;
  assign out_ones  = ones_reg;
  assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe. The expected result of each accepted
// beat is queued and later compared against the beat that leaves the pipe.
module tb_logic_unit_pipe;
  localparam int W      = 8;
  localparam int STAGES = 2;
  localparam int CW     = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [2:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out;
  logic          out_zero;
  logic          out_ones;
  logic [CW-1:0] txn_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W-1:0] exp_q [$];
  logic         stall_prev = 1'b0;
  logic [W-1:0] held_out;
  logic         held_zero;
  logic         held_ones;

  logic [W-1:0] sweep_exp [8] = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'h3C, 8'hC3};

  logic_unit_pipe #(.W(W), .STAGES(STAGES), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_zero  (out_zero),
    .out_ones  (out_ones),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: each op is a 4-entry truth table indexed by {a_bit, b_bit}
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    logic [3:0] tt;
    logic [W-1:0] r;
    case (op)
      3'd0: tt = 4'b1000;
      3'd1: tt = 4'b1110;
      3'd2: tt = 4'b0110;
      3'd3: tt = 4'b0111;
      3'd4: tt = 4'b0001;
      3'd5: tt = 4'b1001;
      3'd6: tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  // Monitor: observe the handshakes that the next rising edge will complete
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_value("hold_out", out, held_out);
        check_value("hold_zero", out_zero, held_zero);
        check_value("hold_ones", out_ones, held_ones);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_value("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check_value("sb_data", out, e);
          check_value("sb_zero", out_zero, e == '0);
          check_value("sb_ones", out_ones, e == '1);
          $display("out beat 0x%02h zero=%0b ones=%0b", out, out_zero, out_ones);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_op));
      stall_prev = out_valid && !out_ready;
      held_out   = out;
      held_zero  = out_zero;
      held_ones  = out_ones;
    end
  end

  // All tasks start and end 1 time unit after a rising edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    logic hs;
    int guard = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!hs && guard < 50);
    if (!hs) check_value("send_timeout", 64'(hs), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_complete();
    int guard = 0;
    while (!(out_valid && out_ready) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!(out_valid && out_ready)) check_value("complete_timeout", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_op = 3'd0; out_ready = 1'b1;
    @(posedge clk); #1;

    // 1: reset held two cycles with in_valid high
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    check_value("rst_out", out, 0);
    check_value("rst_out_valid", out_valid, 0);
    check_value("rst_txn", txn_count, 0);
    check_value("rst_in_ready", in_ready, 1);
    check_value("rst_flags", {out_zero, out_ones}, 0);
    idle(2);

    // 2: op sweep, back to back
    for (int i = 0; i < 8; i++) begin
      send(8'hC3, 8'hA5, 3'(i));
      $display("in beat a=0xC3 b=0xA5 op=%0d", i);
      if (i == 0) check_value("lat_first_not_yet", out_valid, 0);
      if (i == 1) begin
        check_value("lat_first_valid", out_valid, 1);
        check_value("lat_first_data", out, sweep_exp[0]);
      end
    end
    idle(4);
    check_value("sweep_txn", txn_count, 8);

    // 3: flags
    send(8'hFF, 8'hFF, 3'd0);
    send(8'h0F, 8'h0F, 3'd2);
    idle(4);

    // 4: backpressure for 5 cycles while four beats are offered
    do_reset();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(8'(i), 8'hFF, 3'd0);
      end
      begin
        int guard = 0;
        while (!out_valid && guard < 20) begin @(posedge clk); #1; guard++; end
        check_value("bp_valid_seen", out_valid, 1);
        repeat (5) begin
          check_value("bp_out_hold", out, 8'h01);
          check_value("bp_in_ready", in_ready, 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(5);
    check_value("bp_txn", txn_count, 4);

    // 5: reset with two beats in flight
    do_reset();
    send(8'h55, 8'hFF, 3'd0);
    send(8'hAA, 8'hFF, 3'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_value("mid_rst_valid", out_valid, 0);
    check_value("mid_rst_txn", txn_count, 0);
    idle(5);
    check_value("mid_rst_no_stale", out_valid, 0);
    check_value("mid_rst_txn_after", txn_count, 0);

    // 6: counter wrap at CW=4
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      send(8'(i), 8'h3C, 3'(i % 8));
      wait_complete();
      check_value("wrap_txn", txn_count, 64'(i % 16));
    end
    idle(3);
    check_value("sb_drain", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined successor to the two-input single-bit AND gate.
- Applies one of eight bitwise logic operations to two W-bit operands.
- Carries the result through a configurable number of register stages under a valid/ready handshake.
- Produces reduction flags and a completed-transaction counter.
- Sits between an operand producer and a result consumer. Both sides may stall.

Parameters:
W, 8, operand and result width in bits (1..64)
STAGES, 2, pipeline depth in register stages (1..4); latency in cycles with no stall
CW, 16, width of transaction counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept operand beat this cycle
in_a  input  W  operand A
in_b  input  W  operand B
in_op  input  3  operation select, sampled with operands
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result this cycle
out  output  W  result
out_zero  output  1  result is all zeros (qualified by out_valid)
out_ones  output  1  result is all ones (qualified by out_valid)
txn_count  output  CW  count of completed output handshakes

Behaviour:
- Reset: when rst_n=0 at a rising edge, all stage valid bits, stage data, out, out_zero, out_ones and txn_count become 0.
  - Any in-flight beats are discarded; there is no completion for them.
  - Reset mid-operation behaves identically.
- Op encoding, computed combinationally at the input, then registered into stage 1:
  - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR.
  - 110 NOT in_a (in_b ignored), 111 pass in_a.
- Width: all ops are bitwise over W bits; no carries and no sign.
- Flags:
  - out_zero = (out == 0); out_ones = (out == all ones).
  - Both are computed when entering the last stage and registered with the data, never combinationally from out.
- Pipeline: stage k holds {valid, data, zero, ones}.
  - advance = !out_valid | out_ready (global stall).
  - On advance, every stage loads from its predecessor; stage 1 loads {in_valid, f(in_a, in_b, in_op)}.
  - When advance=0, all stages hold.
- in_ready = advance, combinational from out_valid and out_ready only.
  - in_ready must not depend on in_valid.
- Input handshake: in_valid & in_ready. Output handshake: out_valid & out_ready.
- Latency: with out_ready held 1, a beat accepted at edge N appears at out with out_valid=1 after edge N+STAGES-1. It is visible for the cycle following that edge.
- Throughput: 1 beat per cycle with no stall.
- Bubbles: empty stages advance with the pipe and are not collapsed during a stall.
  - in_ready drops whenever the output is stalled, even if interior stages are empty.
- Stability: while out_valid=1 and out_ready=0, out, out_zero and out_ones must hold stable.
- Ordering: results leave in acceptance order; there is no drop and no duplication.
- Counter: txn_count increments by 1 on each output handshake and wraps from 2^CW-1 to 0.
- Simultaneous events:
  - Input and output handshakes may occur in the same cycle; the pipe shifts normally.
  - rst_n=0 overrides all handshakes.
- in_op values are only sampled on an input handshake; values on idle cycles are don't-care.

Test Plan:
1. Reset then idle (W=8, STAGES=2): hold rst_n=0 for 2 cycles with in_valid=1 -> out=0x00, out_valid=0, txn_count=0, in_ready=1 after release.
2. Op sweep with out_ready=1, a=0xC3, b=0xA5, ops 000..111 on consecutive cycles:
   - Expected out: 0x81, 0xE7, 0x66, 0x7E, 0x18, 0x99, 0x3C, 0xC3.
   - First result appears 1 cycle after acceptance, then one per cycle in order.
   - txn_count=8 at the end.
3. Flags:
   - a=0xFF, b=0xFF, op AND -> out=0xFF, out_ones=1, out_zero=0.
   - a=0x0F, b=0x0F, op XOR -> out=0x00, out_zero=1, out_ones=0.
4. Backpressure: stream 4 beats (AND of 0x01..0x04 with 0xFF) while out_ready=0 for 5 cycles.
   - out=0x01 holds stable and in_ready=0 throughout the stall.
   - After out_ready=1: 0x01, 0x02, 0x03, 0x04 are delivered in order with no loss or duplicates; txn_count=4.
5. Reset mid-stream: accept 2 beats, assert rst_n=0 for 1 cycle before either completes -> out_valid=0 the next cycle, txn_count=0, and no stale result emerges afterwards.
6. Counter wrap (CW=4): complete 17 handshakes -> txn_count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
